// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Program-counter register and fetch sequencer. It arbitrates
//            branch redirects, stalls and halt, and presents a valid/ready
//            fetch request to instruction memory.
// Options  : PC_INCR_CHECK_EN enables a sticky incrementer-mismatch check.
// Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter int               INCR_STEP = 1
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] incr_in,
    output logic             fetch_valid,
    input  logic             fetch_ready,
    input  logic             stall,
    input  logic             branch_en,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             halt,
    output logic             halted,
    output logic             incr_err
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FETCH    = 2'd1,
        ST_REDIRECT = 2'd2,
        ST_HALT     = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_stateNext;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] w_pcNext;
    logic             r_fetchValid;
    logic             w_fetchValidNext;
    logic             r_halted;
    logic             w_haltedNext;
    logic             w_accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_pc         <= RESET_VEC;
            r_fetchValid <= 1'b0;
            r_halted     <= 1'b0;
        end else begin
            r_state      <= w_stateNext;
            r_pc         <= w_pcNext;
            r_fetchValid <= w_fetchValidNext;
            r_halted     <= w_haltedNext;
        end
    end

    // Arbitration order within every non-HALT state: halt > branch > stall > advance.
    always_comb begin
        w_stateNext      = r_state;
        w_pcNext         = r_pc;
        w_fetchValidNext = r_fetchValid;
        w_haltedNext     = r_halted;
        w_accept         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (halt) begin
                    w_stateNext      = ST_HALT;
                    w_fetchValidNext = 1'b0;
                    w_haltedNext     = 1'b1;
                end else if (branch_en) begin
                    w_stateNext      = ST_REDIRECT;
                    w_pcNext         = branch_target;
                    w_fetchValidNext = 1'b0;
                end else begin
                    w_stateNext      = ST_FETCH;
                    w_fetchValidNext = !stall;
                end
            end

            ST_FETCH: begin
                if (halt) begin
                    w_stateNext      = ST_HALT;
                    w_fetchValidNext = 1'b0;
                    w_haltedNext     = 1'b1;
                end else if (branch_en) begin
                    w_stateNext      = ST_REDIRECT;
                    w_pcNext         = branch_target;
                    w_fetchValidNext = 1'b0;
                end else if (stall) begin
                    w_fetchValidNext = 1'b0;
                end else if (r_fetchValid && fetch_ready) begin
                    w_pcNext         = incr_in;
                    w_fetchValidNext = 1'b1;
                    w_accept         = 1'b1;
                end else begin
                    // Unaccepted or re-armed request stays stable at the same pc.
                    w_fetchValidNext = 1'b1;
                end
            end

            ST_REDIRECT: begin
                if (halt) begin
                    w_stateNext      = ST_HALT;
                    w_fetchValidNext = 1'b0;
                    w_haltedNext     = 1'b1;
                end else if (branch_en) begin
                    w_pcNext         = branch_target;
                    w_fetchValidNext = 1'b0;
                end else if (stall) begin
                    w_fetchValidNext = 1'b0;
                end else begin
                    w_stateNext      = ST_FETCH;
                    w_fetchValidNext = 1'b1;
                end
            end

            ST_HALT: begin
                w_fetchValidNext = 1'b0;
                w_haltedNext     = 1'b1;
            end

            default: begin
                w_stateNext      = ST_IDLE;
                w_fetchValidNext = 1'b0;
            end
        endcase
    end

    assign pc          = r_pc;
    assign fetch_valid = r_fetchValid;
    assign halted      = r_halted;

`ifdef PC_INCR_CHECK_EN
    localparam logic [WIDTH-1:0] c_STEP = WIDTH'(INCR_STEP);

    logic r_incrErr;

    // Observational only: pc has already loaded incr_in regardless of outcome.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_incrErr <= 1'b0;
        end else if (w_accept && (incr_in != (r_pc + c_STEP))) begin
            r_incrErr <= 1'b1;
        end
    end

    assign incr_err = r_incrErr;
`else
    assign incr_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// Testbench for pc_sequencer: table-driven per-cycle vectors plus a few
// hand-written multi-cycle sequences.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc;
    logic [31:0] incrIn;
    logic        fetchValid;
    logic        fetchReady = 1'b0;
    logic        stall = 1'b0;
    logic        branchEn = 1'b0;
    logic [31:0] branchTarget = '0;
    logic        halt = 1'b0;
    logic        halted;
    logic        incrErr;
    logic [31:0] delta = 32'd1;

    int total = 0;
    int bad   = 0;

`ifdef PC_INCR_CHECK_EN
    localparam logic c_ERR = 1'b1;
`else
    localparam logic c_ERR = 1'b0;
`endif

    always #5 clk = ~clk;

    assign incrIn = pc + delta;

    pc_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .pc           (pc),
        .incr_in      (incrIn),
        .fetch_valid  (fetchValid),
        .fetch_ready  (fetchReady),
        .stall        (stall),
        .branch_en    (branchEn),
        .branch_target(branchTarget),
        .halt         (halt),
        .halted       (halted),
        .incr_err     (incrErr)
    );

    typedef struct {
        string       name;
        logic        rst;
        logic        halt;
        logic        br;
        logic        stall;
        logic        rdy;
        logic [31:0] tgt;
        logic [31:0] delta;
        logic [31:0] ePc;
        logic        eFv;
        logic        eHalted;
        logic        eErr;
    } vec_t;

    vec_t vecs[$];

    function automatic void addV(string n, logic r, logic h, logic b, logic s, logic rd,
                                 logic [31:0] t, logic [31:0] d, logic [31:0] p,
                                 logic fv, logic hd, logic e);
        vec_t v;
        v.name = n; v.rst = r; v.halt = h; v.br = b; v.stall = s; v.rdy = rd;
        v.tgt = t; v.delta = d; v.ePc = p; v.eFv = fv; v.eHalted = hd; v.eErr = e;
        vecs.push_back(v);
    endfunction

    task automatic check(string n, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic drive(logic r, logic h, logic b, logic s, logic rd, logic [31:0] t, logic [31:0] d);
        rst = r; halt = h; branchEn = b; stall = s; fetchReady = rd; branchTarget = t; delta = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //   name          rst h b s rdy tgt            dlt pc             fv hd err
        addV("reset",       1, 0,0,0,1, 32'd0,         1, 32'd0,          0, 0, 0);
        addV("idle2fetch",  0, 0,0,0,1, 32'd0,         1, 32'd0,          1, 0, 0);
        addV("run1",        0, 0,0,0,1, 32'd0,         1, 32'd1,          1, 0, 0);
        addV("run2",        0, 0,0,0,1, 32'd0,         1, 32'd2,          1, 0, 0);
        addV("run3",        0, 0,0,0,1, 32'd0,         1, 32'd3,          1, 0, 0);
        addV("bp1",         0, 0,0,0,0, 32'd0,         1, 32'd3,          1, 0, 0);
        addV("bp2",         0, 0,0,0,0, 32'd0,         1, 32'd3,          1, 0, 0);
        addV("bp3",         0, 0,0,0,0, 32'd0,         1, 32'd3,          1, 0, 0);
        addV("bpRelease",   0, 0,0,0,1, 32'd0,         1, 32'd4,          1, 0, 0);
        addV("br15",        0, 0,1,0,1, 32'd15,        1, 32'd15,         0, 0, 0);
        addV("fetch15",     0, 0,0,0,1, 32'd0,         1, 32'd15,         1, 0, 0);
        addV("brStall64",   0, 0,1,1,1, 32'd64,        1, 32'd64,         0, 0, 0);
        addV("fetch64",     0, 0,0,0,1, 32'd0,         1, 32'd64,         1, 0, 0);
        addV("adv65",       0, 0,0,0,1, 32'd0,         1, 32'd65,         1, 0, 0);
        addV("stall1",      0, 0,0,1,1, 32'd0,         1, 32'd65,         0, 0, 0);
        addV("stall2",      0, 0,0,1,1, 32'd0,         1, 32'd65,         0, 0, 0);
        addV("unstall",     0, 0,0,0,1, 32'd0,         1, 32'd65,         1, 0, 0);
        addV("adv66",       0, 0,0,0,1, 32'd0,         1, 32'd66,         1, 0, 0);
        addV("br300",       0, 0,1,0,1, 32'd300,       1, 32'd300,        0, 0, 0);
        addV("redirStall",  0, 0,0,1,1, 32'd0,         1, 32'd300,        0, 0, 0);
        addV("fetch300",    0, 0,0,0,1, 32'd0,         1, 32'd300,        1, 0, 0);
        addV("adv301",      0, 0,0,0,1, 32'd0,         1, 32'd301,        1, 0, 0);
        addV("br100",       0, 0,1,0,1, 32'd100,       1, 32'd100,        0, 0, 0);
        addV("br200",       0, 0,1,0,1, 32'd200,       1, 32'd200,        0, 0, 0);
        addV("fetch200",    0, 0,0,0,1, 32'd0,         1, 32'd200,        1, 0, 0);
        addV("adv201",      0, 0,0,0,1, 32'd0,         1, 32'd201,        1, 0, 0);
        addV("brMax",       0, 0,1,0,1, 32'hFFFFFFFF,  1, 32'hFFFFFFFF,   0, 0, 0);
        addV("fetchMax",    0, 0,0,0,1, 32'd0,         1, 32'hFFFFFFFF,   1, 0, 0);
        addV("wrap0",       0, 0,0,0,1, 32'd0,         1, 32'd0,          1, 0, 0);
        addV("haltBr",      0, 1,1,0,1, 32'd77,        1, 32'd0,          0, 1, 0);
        addV("haltIgnore",  0, 0,1,1,1, 32'd5,         1, 32'd0,          0, 1, 0);
        addV("haltRst",     1, 0,0,0,1, 32'd0,         1, 32'd0,          0, 0, 0);
        addV("r2fetch",     0, 0,0,0,1, 32'd0,         1, 32'd0,          1, 0, 0);
        addV("r2adv1",      0, 0,0,0,1, 32'd0,         1, 32'd1,          1, 0, 0);
        addV("r2adv2",      0, 0,0,0,1, 32'd0,         1, 32'd2,          1, 0, 0);
        addV("r2adv3",      0, 0,0,0,1, 32'd0,         1, 32'd3,          1, 0, 0);
        addV("badIncr",     0, 0,0,0,1, 32'd0,         2, 32'd5,          1, 0, c_ERR);
        addV("errSticky",   0, 0,0,0,1, 32'd0,         1, 32'd6,          1, 0, c_ERR);
        addV("errRst",      1, 0,0,0,1, 32'd0,         1, 32'd0,          0, 0, 0);
        addV("r3fetch",     0, 0,0,0,1, 32'd0,         1, 32'd0,          1, 0, 0);
        addV("br9",         0, 0,1,0,1, 32'd9,         1, 32'd9,          0, 0, 0);
        addV("rstInRedir",  1, 0,0,0,1, 32'd0,         1, 32'd0,          0, 0, 0);
        addV("r4fetch",     0, 0,0,0,1, 32'd0,         1, 32'd0,          1, 0, 0);
        addV("r5rst",       1, 0,0,0,1, 32'd0,         1, 32'd0,          0, 0, 0);
        addV("haltIdle",    0, 1,0,0,1, 32'd0,         1, 32'd0,          0, 1, 0);
        addV("haltIdleRst", 1, 0,0,0,1, 32'd0,         1, 32'd0,          0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].halt, vecs[i].br, vecs[i].stall, vecs[i].rdy,
                  vecs[i].tgt, vecs[i].delta);
            step();
            check({vecs[i].name, ".pc"},     pc,               vecs[i].ePc);
            check({vecs[i].name, ".fv"},     {31'd0, fetchValid}, {31'd0, vecs[i].eFv});
            check({vecs[i].name, ".halted"}, {31'd0, halted},  {31'd0, vecs[i].eHalted});
            check({vecs[i].name, ".err"},    {31'd0, incrErr}, {31'd0, vecs[i].eErr});
        end

        // Bounded wait for the first fetch after reset: exactly one IDLE cycle.
        begin
            int waited;
            logic seen;
            drive(1, 0, 0, 0, 1, 0, 1);
            step();
            drive(0, 0, 0, 0, 0, 0, 1);
            waited = 0;
            seen = 1'b0;
            while (!seen && waited < 8) begin
                step();
                waited++;
                if (fetchValid) seen = 1'b1;
            end
            check("firstFetchSeen", {31'd0, seen}, 32'd1);
            check("firstFetchLat",  waited, 32'd1);
            check("firstFetchPc",   pc, 32'd0);
        end

        // Branch drops an outstanding unaccepted request (fetch_ready low).
        drive(0, 0, 1, 0, 0, 32'd40, 1);
        step();
        check("dropReq.pc", pc, 32'd40);
        check("dropReq.fv", {31'd0, fetchValid}, 32'd0);
        drive(0, 0, 0, 0, 0, 0, 1);
        step();
        check("dropReqRefetch.pc", pc, 32'd40);
        check("dropReqRefetch.fv", {31'd0, fetchValid}, 32'd1);

        // HALT is absorbing against any combination of other inputs.
        drive(0, 1, 0, 0, 1, 0, 1);
        step();
        for (int k = 0; k < 6; k++) begin
            drive(0, k[0], k[1], k[2], 1'b1, 32'd1234 + k, 1);
            step();
            check("haltAbs.pc", pc, 32'd40);
            check("haltAbs.fv", {31'd0, fetchValid}, 32'd0);
            check("haltAbs.halted", {31'd0, halted}, 32'd1);
        end
        drive(1, 0, 0, 0, 0, 0, 1);
        step();
        check("finalRst.halted", {31'd0, halted}, 32'd0);
        check("finalRst.pc", pc, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter register and fetch sequencer for the MIPS datapath.
- Drives the current PC into the incrementer's pcin and registers the incrementer's pcout back as the next sequential PC.
- Arbitrates branch redirects, stalls and halt.
- Presents a valid/ready fetch request to instruction memory.

Parameters:
- WIDTH, 32, PC width in bits.
- RESET_VEC, 0, PC value loaded on reset.
- INCR_STEP, 1, expected increment between sequential PCs (word-addressed); used only by the optional check.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- pc  output  WIDTH  current PC; drives incrementer pcin and imem address.
- incr_in  input  WIDTH  incrementer pcout (combinational function of pc).
- fetch_valid  output  1  fetch request for address pc is valid this cycle.
- fetch_ready  input  1  imem accepts the request this cycle.
- stall  input  1  hold PC; suppress fetch.
- branch_en  input  1  redirect request.
- branch_target  input  WIDTH  redirect address, used unmodified.
- halt  input  1  stop fetching until reset.
- halted  output  1  high while in HALT.
- incr_err  output  1  sticky incrementer-mismatch flag; constant 0 without PC_INCR_CHECK_EN.

Behaviour:
- Reset (rst=1 at an edge, any state, including mid-redirect): pc=RESET_VEC, state=IDLE, fetch_valid=0, halted=0, incr_err=0.
- States: IDLE, FETCH, REDIRECT, HALT. The state register, pc, fetch_valid, halted and incr_err are all registered outputs.
- Priority at each edge: rst > halt > branch_en > stall > normal advance.
- IDLE
  - Lasts exactly one cycle after reset.
  - branch_en → pc=branch_target, REDIRECT.
  - Otherwise → FETCH, fetch_valid=1, pc unchanged.
- FETCH
  - Handshake completes when fetch_valid && fetch_ready && !stall.
  - On completion: pc<=incr_in, stay FETCH, fetch_valid stays 1.
  - stall=1: pc held, fetch_valid<=0 next cycle. It returns to 1 the cycle after stall drops.
  - fetch_ready=0 and stall=0: pc held, fetch_valid held at 1. The request must remain stable until accepted.
  - branch_en: pc<=branch_target, fetch_valid<=0, → REDIRECT. An outstanding un-accepted request is dropped.
- REDIRECT
  - One bubble cycle with fetch_valid=0.
  - Next → FETCH with fetch_valid=1 at the new pc.
  - branch_en again: load the new target and stay REDIRECT one more cycle (last branch wins).
  - stall in REDIRECT: remain REDIRECT until stall drops.
- halt (any non-HALT state): → HALT, fetch_valid<=0, halted<=1, pc held. Same-cycle branch_en is ignored.
- HALT
  - Absorbing; only rst leaves it.
  - branch_en, stall and fetch_ready are ignored.
- Width/wrap
  - pc is taken from incr_in without modification; pc=all-ones with incr_in=0 advances to 0 legally.
  - No alignment masking; branch_target is used as-is.
- Latency: pc reflects an accepted fetch or a branch one cycle after the triggering edge.

Optional Feature:
- Macro: PC_INCR_CHECK_EN.
- Defined: on every completed fetch handshake, compare incr_in against (pc+INCR_STEP) mod 2^WIDTH.
  - On mismatch, incr_err<=1 (sticky until rst).
  - pc still loads incr_in; the check is observational only.
- Undefined: no comparator logic; incr_err tied to 0.

Test Plan:
- Reset then run, RESET_VEC=0, fetch_ready=1, incrementer in loop: cycle after IDLE pc=0 with fetch_valid=1, then pc=1,2,3 on consecutive cycles, incr_err=0.
- Backpressure: fetch_ready=0 for 3 cycles at pc=3 → pc stays 3 and fetch_valid stays 1; on fetch_ready=1 → pc=4 next cycle.
- Branch with stall: at pc=15 assert stall and branch_en together with target 64 → pc=64 and fetch_valid=0 (REDIRECT). Next cycle fetch_valid=1 at 64, then 65.
- Back-to-back branches: branch to 100 then 200 in the following cycle → fetch_valid stays 0 for 2 cycles, first fetch at 200; address 100 is never presented valid.
- Halt and wrap:
  - Force pc to 32'hFFFFFFFF via branch, fetch → pc=0.
  - Then assert halt with branch_en → halted=1, pc=0, fetch_valid=0, branch ignored.
  - rst → pc=RESET_VEC, halted=0.
- With PC_INCR_CHECK_EN: drive incr_in=pc+2 for one accepted fetch at pc=3 → pc=5, incr_err=1 and it stays 1 until rst. Without the macro, the same stimulus leaves incr_err=0.
